router_pkt_reg: RTL and testbench

ROUTER_PKT_REG -- requirements
Module: router_pkt_reg

---
 rtl/router_pkt_reg.sv | 205 ++++++++++++++++++++
 tb/tb_router_pkt_reg.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_pkt_reg.sv
// Router packet register: stages header, payload and parity words toward the FIFO,
// parks words in a small in-order hold buffer while the FIFO is full, and checks parity.
module router_pkt_reg #(
  parameter int DATA_W      = 8,
  parameter int HOLD_DEPTH  = 2,
  parameter int PARITY_MODE = 0,
  localparam int CNT_W      = $clog2(HOLD_DEPTH + 1)
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              pkt_valid,
  input  logic              fifo_full,
  input  logic              detect_add,
  input  logic              lfd_state,
  input  logic              ld_state,
  input  logic              laf_state,
  input  logic              full_state,
  input  logic              rst_int_reg,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              parity_done,
  output logic              low_pkt_valid,
  output logic              err,
  output logic [CNT_W-1:0]  hold_cnt,
  output logic              hold_ovf
);

  typedef enum logic [2:0] {
    CMD_IDLE,
    CMD_LFD,
    CMD_LD,
    CMD_LAF,
    CMD_FULL
  } cmd_t;

  cmd_t cmd;

  logic [DATA_W-1:0]     acc, header, rx_parity;
  logic [DATA_W-1:0]     hbuf [HOLD_DEPTH];
  logic [HOLD_DEPTH-1:0] hpar;
  logic                  chk_pend;

  logic [DATA_W-1:0]     dout_nx, acc_nx, header_nx, rx_parity_nx;
  logic [DATA_W-1:0]     hbuf_nx [HOLD_DEPTH];
  logic [HOLD_DEPTH-1:0] hpar_nx;
  logic [CNT_W-1:0]      hold_cnt_nx;
  logic                  dout_valid_nx, parity_done_nx, low_pkt_valid_nx, err_nx;
  logic                  hold_ovf_nx, chk_pend_nx;
  logic                  push_req, push_par, wr_par;
  logic                  hold_full, hold_empty;

  function automatic logic [DATA_W-1:0] fold(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    if (PARITY_MODE == 1) return a + b;
    else                  return a ^ b;
  endfunction

  assign hold_full  = (hold_cnt == CNT_W'(HOLD_DEPTH));
  assign hold_empty = (hold_cnt == '0);

  always_comb begin
    cmd = CMD_IDLE;
    if (lfd_state)       cmd = CMD_LFD;
    else if (ld_state)   cmd = CMD_LD;
    else if (laf_state)  cmd = CMD_LAF;
    else if (full_state) cmd = CMD_FULL;
  end

  always_comb begin
    dout_nx          = dout;
    dout_valid_nx    = 1'b0;
    parity_done_nx   = parity_done;
    low_pkt_valid_nx = low_pkt_valid;
    err_nx           = err;
    chk_pend_nx      = 1'b0;
    hold_cnt_nx      = hold_cnt;
    hold_ovf_nx      = hold_ovf;
    acc_nx           = acc;
    header_nx        = header;
    rx_parity_nx     = rx_parity;
    hbuf_nx          = hbuf;
    hpar_nx          = hpar;
    push_req         = 1'b0;
    push_par         = 1'b0;
    wr_par           = 1'b0;

    if (rst_int_reg) begin
      acc_nx      = '0;
      hold_cnt_nx = '0;
      hold_ovf_nx = 1'b0;
      err_nx      = 1'b0;
      hpar_nx     = '0;
      for (int unsigned i = 0; i < HOLD_DEPTH; i++) hbuf_nx[i] = '0;
    end else begin
      // The comparison uses the accumulator as it stood when parity_done rose.
      if (chk_pend) err_nx = (acc != rx_parity);

      case (cmd)
        CMD_LFD: begin
          dout_nx       = header;
          dout_valid_nx = 1'b1;
        end
        CMD_LD: begin
          if (pkt_valid) begin
            acc_nx = fold(acc, data_in);
            if (!fifo_full) begin
              dout_nx       = data_in;
              dout_valid_nx = 1'b1;
            end else begin
              push_req = 1'b1;
            end
          end else if (!low_pkt_valid) begin
            rx_parity_nx     = data_in;
            low_pkt_valid_nx = 1'b1;
            if (!fifo_full) begin
              dout_nx       = data_in;
              dout_valid_nx = 1'b1;
              wr_par        = 1'b1;
            end else begin
              push_req = 1'b1;
              push_par = 1'b1;
            end
          end
        end
        CMD_LAF: begin
          if (!fifo_full && !hold_empty) begin
            dout_nx       = hbuf[0];
            dout_valid_nx = 1'b1;
            wr_par        = hpar[0];
            for (int unsigned i = 0; i + 1 < HOLD_DEPTH; i++) begin
              hbuf_nx[i] = hbuf[i+1];
              hpar_nx[i] = hpar[i+1];
            end
            hbuf_nx[HOLD_DEPTH-1] = '0;
            hpar_nx[HOLD_DEPTH-1] = 1'b0;
            hold_cnt_nx           = hold_cnt - 1'b1;
          end
        end
        default: ;
      endcase

      if (push_req) begin
        if (hold_full) begin
          hold_ovf_nx = 1'b1;
        end else begin
          for (int unsigned i = 0; i < HOLD_DEPTH; i++) begin
            if (CNT_W'(i) == hold_cnt) begin
              hbuf_nx[i] = data_in;
              hpar_nx[i] = push_par;
            end
          end
          hold_cnt_nx = hold_cnt + 1'b1;
        end
      end

      if (wr_par) begin
        parity_done_nx = 1'b1;
        if (!parity_done) chk_pend_nx = 1'b1;
      end

      if (detect_add) begin
        if (pkt_valid) begin
          header_nx = data_in;
          acc_nx    = data_in;
        end
        parity_done_nx   = 1'b0;
        low_pkt_valid_nx = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      dout          <= '0;
      dout_valid    <= 1'b0;
      parity_done   <= 1'b0;
      low_pkt_valid <= 1'b0;
      err           <= 1'b0;
      chk_pend      <= 1'b0;
      hold_cnt      <= '0;
      hold_ovf      <= 1'b0;
      acc           <= '0;
      header        <= '0;
      rx_parity     <= '0;
      hpar          <= '0;
      for (int unsigned i = 0; i < HOLD_DEPTH; i++) hbuf[i] <= '0;
    end else begin
      dout          <= dout_nx;
      dout_valid    <= dout_valid_nx;
      parity_done   <= parity_done_nx;
      low_pkt_valid <= low_pkt_valid_nx;
      err           <= err_nx;
      chk_pend      <= chk_pend_nx;
      hold_cnt      <= hold_cnt_nx;
      hold_ovf      <= hold_ovf_nx;
      acc           <= acc_nx;
      header        <= header_nx;
      rx_parity     <= rx_parity_nx;
      hpar          <= hpar_nx;
      hbuf          <= hbuf_nx;
    end
  end

endmodule

// File: tb/tb_router_pkt_reg.sv
// Bench for router_pkt_reg: spec vector table, hand corner sequences and random
// stimulus against a queue-based reference model (XOR and additive-checksum instances).
module tb_router_pkt_reg;

  localparam int DW = 8;
  localparam int HD = 2;
  localparam int CW = $clog2(HD + 1);

  logic          clock = 1'b0;
  logic          resetn, pkt_valid, fifo_full, detect_add, lfd_state, ld_state;
  logic          laf_state, full_state, rst_int_reg;
  logic [DW-1:0] data_in;

  logic [DW-1:0] dout, dout_s;
  logic          dout_valid, parity_done, low_pkt_valid, err, hold_ovf;
  logic          dv_s, pd_s, lpv_s, err_s, ovf_s;
  logic [CW-1:0] hold_cnt, cnt_s;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  router_pkt_reg #(.DATA_W(DW), .HOLD_DEPTH(HD), .PARITY_MODE(0)) dut (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .fifo_full(fifo_full),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
    .data_in(data_in), .dout(dout), .dout_valid(dout_valid), .parity_done(parity_done),
    .low_pkt_valid(low_pkt_valid), .err(err), .hold_cnt(hold_cnt), .hold_ovf(hold_ovf)
  );

  router_pkt_reg #(.DATA_W(DW), .HOLD_DEPTH(HD), .PARITY_MODE(1)) dut_sum (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .fifo_full(fifo_full),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
    .data_in(data_in), .dout(dout_s), .dout_valid(dv_s), .parity_done(pd_s),
    .low_pkt_valid(lpv_s), .err(err_s), .hold_cnt(cnt_s), .hold_ovf(ovf_s)
  );

  // Reference model: packet words kept as a list, hold buffer as a queue.
  logic [7:0] m_words [$];
  logic [7:0] hq [$];
  bit         hpq [$];
  logic [7:0] m_dout, m_hdr, m_rxp;
  bit         m_dv, m_pd, m_lpv, m_err_x, m_err_s, m_ovf, m_pend, m_wrote;

  function automatic logic [7:0] xor_all();
    logic [7:0] r = 8'h00;
    foreach (m_words[i]) r = r ^ m_words[i];
    return r;
  endfunction

  function automatic logic [7:0] sum_all();
    int s = 0;
    foreach (m_words[i]) s = s + int'(m_words[i]);
    return 8'(s % 256);
  endfunction

  task automatic model_reset();
    m_words.delete(); hq.delete(); hpq.delete();
    m_dout = 8'h00; m_hdr = 8'h00; m_rxp = 8'h00;
    m_dv = 0; m_pd = 0; m_lpv = 0; m_err_x = 0; m_err_s = 0; m_ovf = 0; m_pend = 0;
  endtask

  task automatic model_emit(input logic [7:0] w, input bit par);
    if (!fifo_full) begin
      m_dout = w; m_dv = 1; m_wrote = par;
    end else if (hq.size() < HD) begin
      hq.push_back(w); hpq.push_back(par);
    end else begin
      m_ovf = 1;
    end
  endtask

  task automatic model_step();
    bit pend_now;
    pend_now = m_pend;
    m_pend = 0; m_dv = 0; m_wrote = 0;
    if (rst_int_reg) begin
      m_words.delete(); hq.delete(); hpq.delete();
      m_ovf = 0; m_err_x = 0; m_err_s = 0;
    end else begin
      if (pend_now) begin
        m_err_x = (xor_all() != m_rxp);
        m_err_s = (sum_all() != m_rxp);
      end
      if (lfd_state) begin
        m_dout = m_hdr; m_dv = 1;
      end else if (ld_state) begin
        if (pkt_valid) begin
          m_words.push_back(data_in);
          model_emit(data_in, 1'b0);
        end else if (!m_lpv) begin
          m_rxp = data_in; m_lpv = 1;
          model_emit(data_in, 1'b1);
        end
      end else if (laf_state && !fifo_full && hq.size() > 0) begin
        m_dout = hq.pop_front(); m_dv = 1; m_wrote = hpq.pop_front();
      end
      if (m_wrote) begin
        if (!m_pd) m_pend = 1;
        m_pd = 1;
      end
      if (detect_add) begin
        if (pkt_valid) begin
          m_hdr = data_in;
          m_words.delete();
          m_words.push_back(data_in);
        end
        m_pd = 0; m_lpv = 0;
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    chk("model dout", dout, m_dout);
    chk("model dout_valid", dout_valid, m_dv);
    chk("model parity_done", parity_done, m_pd);
    chk("model low_pkt_valid", low_pkt_valid, m_lpv);
    chk("model err", err, m_err_x);
    chk("model hold_cnt", hold_cnt, hq.size());
    chk("model hold_ovf", hold_ovf, m_ovf);
    chk("model sum dout", dout_s, m_dout);
    chk("model sum err", err_s, m_err_s);
  endtask

  task automatic tick();
    if (resetn) model_step();
    else model_reset();
    @(posedge clock);
    #1;
    compare_model();
  endtask

  task automatic drive(input bit pv, input bit ff, input bit da, input bit lfd,
                       input bit ld, input bit laf, input bit rst, input logic [7:0] d);
    pkt_valid = pv; fifo_full = ff; detect_add = da; lfd_state = lfd;
    ld_state = ld; laf_state = laf; full_state = 1'b0; rst_int_reg = rst; data_in = d;
    tick();
  endtask

  typedef struct {
    bit         pv, ff, da, lfd, ld, laf, rst;
    logic [7:0] din;
    logic [7:0] e_dout;
    bit         e_dv, e_pd, e_lpv, e_err;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mkv(bit pv, bit ff, bit da, bit lfd, bit ld, bit laf, bit rst,
                               logic [7:0] din, logic [7:0] e_dout,
                               bit e_dv, bit e_pd, bit e_lpv, bit e_err);
    vec_t v;
    v.pv = pv; v.ff = ff; v.da = da; v.lfd = lfd; v.ld = ld; v.laf = laf; v.rst = rst;
    v.din = din; v.e_dout = e_dout; v.e_dv = e_dv; v.e_pd = e_pd; v.e_lpv = e_lpv;
    v.e_err = e_err;
    return v;
  endfunction

  task automatic run_table(input int first, input int count);
    vec_t v;
    for (int i = first; i < first + count; i++) begin
      v = tbl[i];
      drive(v.pv, v.ff, v.da, v.lfd, v.ld, v.laf, v.rst, v.din);
      chk($sformatf("vec%0d dout", i), dout, v.e_dout);
      chk($sformatf("vec%0d dout_valid", i), dout_valid, v.e_dv);
      chk($sformatf("vec%0d parity_done", i), parity_done, v.e_pd);
      chk($sformatf("vec%0d low_pkt_valid", i), low_pkt_valid, v.e_lpv);
      chk($sformatf("vec%0d err", i), err, v.e_err);
    end
  endtask

  task automatic send_head(input logic [7:0] h);
    drive(1, 0, 1, 0, 0, 0, 0, h);
    drive(0, 0, 0, 1, 0, 0, 0, 8'h00);
  endtask

  initial begin
    // Clean packet 05 / 11..55 / 14, then the same packet with bad parity 15.
    //                 pv ff da lfd ld laf rst  din    dout  dv pd lpv err
    tbl.push_back(mkv(1, 0, 1, 0,  0, 0,  0,  8'h05, 8'h00, 0, 0, 0,  0));
    tbl.push_back(mkv(0, 0, 0, 1,  0, 0,  0,  8'h00, 8'h05, 1, 0, 0,  0));
    tbl.push_back(mkv(1, 0, 0, 0,  1, 0,  0,  8'h11, 8'h11, 1, 0, 0,  0));
    tbl.push_back(mkv(1, 0, 0, 0,  1, 0,  0,  8'h22, 8'h22, 1, 0, 0,  0));
    tbl.push_back(mkv(1, 0, 0, 0,  1, 0,  0,  8'h33, 8'h33, 1, 0, 0,  0));
    tbl.push_back(mkv(1, 0, 0, 0,  1, 0,  0,  8'h44, 8'h44, 1, 0, 0,  0));
    tbl.push_back(mkv(1, 0, 0, 0,  1, 0,  0,  8'h55, 8'h55, 1, 0, 0,  0));
    tbl.push_back(mkv(0, 0, 0, 0,  1, 0,  0,  8'h14, 8'h14, 1, 1, 1,  0));
    tbl.push_back(mkv(0, 0, 0, 0,  0, 0,  0,  8'h00, 8'h14, 0, 1, 1,  0));
    tbl.push_back(mkv(1, 0, 1, 0,  0, 0,  0,  8'h05, 8'h14, 0, 0, 0,  0));
    tbl.push_back(mkv(0, 0, 0, 1,  0, 0,  0,  8'h00, 8'h05, 1, 0, 0,  0));
    tbl.push_back(mkv(1, 0, 0, 0,  1, 0,  0,  8'h11, 8'h11, 1, 0, 0,  0));
    tbl.push_back(mkv(1, 0, 0, 0,  1, 0,  0,  8'h22, 8'h22, 1, 0, 0,  0));
    tbl.push_back(mkv(1, 0, 0, 0,  1, 0,  0,  8'h33, 8'h33, 1, 0, 0,  0));
    tbl.push_back(mkv(1, 0, 0, 0,  1, 0,  0,  8'h44, 8'h44, 1, 0, 0,  0));
    tbl.push_back(mkv(1, 0, 0, 0,  1, 0,  0,  8'h55, 8'h55, 1, 0, 0,  0));
    tbl.push_back(mkv(0, 0, 0, 0,  1, 0,  0,  8'h15, 8'h15, 1, 1, 1,  0));
    tbl.push_back(mkv(0, 0, 0, 0,  0, 0,  0,  8'h00, 8'h15, 0, 1, 1,  1));
    tbl.push_back(mkv(0, 0, 0, 0,  0, 0,  1,  8'h00, 8'h15, 0, 1, 1,  0));

    resetn = 1'b0; pkt_valid = 0; fifo_full = 0; detect_add = 0; lfd_state = 0;
    ld_state = 0; laf_state = 0; full_state = 0; rst_int_reg = 0; data_in = '0;
    model_reset();
    #1;
    chk("reset dout", dout, 0);
    chk("reset dout_valid", dout_valid, 0);
    chk("reset hold_cnt", hold_cnt, 0);
    chk("reset sum err", err_s, 0);
    repeat (2) @(negedge clock);
    resetn = 1'b1;

    run_table(0, tbl.size());

    // Two payload words parked while the FIFO is full, then drained in order.
    send_head(8'h05);
    drive(1, 0, 0, 0, 1, 0, 0, 8'h11);
    drive(1, 1, 0, 0, 1, 0, 0, 8'h22);
    drive(1, 1, 0, 0, 1, 0, 0, 8'h33);
    chk("hold two cnt", hold_cnt, 2);
    chk("hold two no write", dout_valid, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 8'h00);
    chk("pop1 dout", dout, 8'h22);
    chk("pop1 cnt", hold_cnt, 1);
    drive(0, 0, 0, 0, 0, 1, 0, 8'h00);
    chk("pop2 dout", dout, 8'h33);
    chk("pop2 cnt", hold_cnt, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 8'h00);
    chk("pop empty valid", dout_valid, 0);
    chk("pop empty dout", dout, 8'h33);
    drive(0, 0, 0, 0, 0, 0, 1, 8'h00);

    // Overflow: third parked word is dropped and never appears.
    send_head(8'h05);
    drive(1, 0, 0, 0, 1, 0, 0, 8'h11);
    drive(1, 1, 0, 0, 1, 0, 0, 8'h22);
    drive(1, 1, 0, 0, 1, 0, 0, 8'h33);
    drive(1, 1, 0, 0, 1, 0, 0, 8'h44);
    chk("ovf flag", hold_ovf, 1);
    chk("ovf cnt", hold_cnt, 2);
    drive(0, 0, 0, 0, 0, 1, 0, 8'h00);
    chk("ovf pop1", dout, 8'h22);
    drive(0, 0, 0, 0, 0, 1, 0, 8'h00);
    chk("ovf pop2", dout, 8'h33);
    drive(0, 0, 0, 0, 0, 1, 0, 8'h00);
    chk("ovf pop3 none", dout_valid, 0);
    drive(1, 1, 0, 0, 1, 0, 0, 8'h66);
    drive(0, 0, 0, 0, 0, 0, 1, 8'h00);
    chk("rst_int ovf", hold_ovf, 0);
    chk("rst_int cnt", hold_cnt, 0);

    // Parity word parked, parity_done rises only when it is popped.
    send_head(8'h05);
    drive(1, 0, 0, 0, 1, 0, 0, 8'h11);
    drive(1, 0, 0, 0, 1, 0, 0, 8'h22);
    drive(1, 0, 0, 0, 1, 0, 0, 8'h33);
    drive(1, 0, 0, 0, 1, 0, 0, 8'h44);
    drive(1, 1, 0, 0, 1, 0, 0, 8'h55);
    drive(0, 1, 0, 0, 1, 0, 0, 8'h14);
    chk("parked lpv", low_pkt_valid, 1);
    chk("parked pd", parity_done, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 8'h00);
    chk("parked pop55", dout, 8'h55);
    chk("parked pd still 0", parity_done, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 8'h00);
    chk("parked pop14", dout, 8'h14);
    chk("parked pd rise", parity_done, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 8'h00);
    chk("parked err", err, 0);

    // Additive checksum instance: 04+F0+20+10 = 0x24 mod 256.
    send_head(8'h04);
    drive(1, 0, 0, 0, 1, 0, 0, 8'hF0);
    drive(1, 0, 0, 0, 1, 0, 0, 8'h20);
    drive(1, 0, 0, 0, 1, 0, 0, 8'h10);
    drive(0, 0, 0, 0, 1, 0, 0, 8'h24);
    drive(0, 0, 0, 0, 0, 0, 0, 8'h00);
    chk("sum good err", err_s, 0);
    chk("xor on sum pkt err", err, 1);
    send_head(8'h04);
    drive(1, 0, 0, 0, 1, 0, 0, 8'hF0);
    drive(1, 0, 0, 0, 1, 0, 0, 8'h20);
    drive(1, 0, 0, 0, 1, 0, 0, 8'h10);
    drive(0, 0, 0, 0, 1, 0, 0, 8'h25);
    drive(0, 0, 0, 0, 0, 0, 0, 8'h00);
    chk("sum bad err", err_s, 1);
    drive(0, 0, 0, 0, 0, 0, 1, 8'h00);

    // Asynchronous reset between edges mid-payload, then a clean packet.
    send_head(8'h05);
    drive(1, 0, 0, 0, 1, 0, 0, 8'h11);
    drive(1, 1, 0, 0, 1, 0, 0, 8'h22);
    #2;
    resetn = 1'b0;
    #1;
    chk("async dout", dout, 0);
    chk("async dout_valid", dout_valid, 0);
    chk("async hold_cnt", hold_cnt, 0);
    chk("async lpv", low_pkt_valid, 0);
    chk("async pd", parity_done, 0);
    chk("async err", err, 0);
    chk("async ovf", hold_ovf, 0);
    model_reset();
    pkt_valid = 0; fifo_full = 0; detect_add = 0; lfd_state = 0; ld_state = 0;
    laf_state = 0; full_state = 0; rst_int_reg = 0; data_in = '0;
    #2;
    resetn = 1'b1;
    run_table(0, 9);

    // Random control/data traffic against the reference model.
    for (int n = 0; n < 800; n++) begin
      pkt_valid   = ($urandom_range(0, 3) != 0);
      fifo_full   = ($urandom_range(0, 2) == 0);
      detect_add  = ($urandom_range(0, 11) == 0);
      lfd_state   = ($urandom_range(0, 9) == 0);
      ld_state    = ($urandom_range(0, 1) == 0);
      laf_state   = ($urandom_range(0, 2) == 0);
      full_state  = ($urandom_range(0, 3) == 0);
      rst_int_reg = ($urandom_range(0, 39) == 0);
      data_in     = 8'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
